// File: rtl/game_session_pkg.sv
// Shared types, constants and small helpers for the game session controller.
package game_session_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAYING   = 3'd1,
        DYING     = 3'd2,
        RESPAWN   = 3'd3,
        GAME_OVER = 3'd4,
        WON       = 3'd5
    } game_state_t;

    localparam logic [15:0] SCORE_MAX = 16'hFFFF;

    // Enemy masks are at most eight wide, so counts are taken over a byte.
    function automatic int unsigned popcount8(input logic [7:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bits[i]) n++;
        end
        return n;
    endfunction

    // Score additions clamp at the top of the 16-bit range instead of wrapping.
    function automatic logic [15:0] score_add(input logic [15:0] base, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {17'd0, base} + {1'b0, inc};
        if (sum > {17'd0, SCORE_MAX}) return SCORE_MAX;
        return sum[15:0];
    endfunction

    // Thermometer bar of remaining lives, capped at seven lit segments.
    function automatic logic [6:0] lives_bar(input logic [3:0] n);
        logic [6:0] bar;
        for (int i = 0; i < 7; i++) begin
            bar[i] = (n > 4'(i));
        end
        return bar;
    endfunction

endpackage

// File: rtl/game_session_controller_edge_pulse.sv
// Optional synchroniser chain followed by a registered rising-edge detector.
// The input is normalised to active-high first, so every flop resets to the
// inactive level regardless of polarity.
module edge_pulse #(
    parameter int SYNC_STAGES = 0,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic active;
    logic sampled;
    logic prev;

    assign active = ACTIVE_LOW ? ~level : level;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign sampled = active;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift the asynchronous level through the synchroniser chain.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= SYNC_STAGES'({sync_q, active});
                end
            end

            assign sampled = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Remember the previous level and emit one pulse per inactive-to-active change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= sampled;
            pulse <= sampled & ~prev;
        end
    end

endmodule

// File: rtl/game_session_controller.sv
// Session sequencer: title, play, death, respawn, game-over and win flow.
// Owns the frame tick, countdown timer, lives, score and enemy alive mask,
// and tells the game logic when to freeze and when to reload positions.
module game_session_controller
    import game_session_pkg::*;
#(
    parameter int NUM_ENEMIES       = 2,
    parameter int FRAMES_PER_SECOND = 60,
    parameter int TIME_LIMIT        = 300,
    parameter int START_LIVES       = 3,
    parameter int DEATH_FRAMES      = 90,
    parameter int STOMP_POINTS      = 100,
    parameter bit VSYNC_ACTIVE_LOW  = 1'b1,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic                   vga_clock,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   start_button,
    input  logic [NUM_ENEMIES-1:0] enemy_hit,
    input  logic [NUM_ENEMIES-1:0] enemy_stomp,
    input  logic                   mario_fell,
    input  logic                   goal_reached,
    output game_state_t            state,
    output logic                   frame_tick,
    output logic                   freeze,
    output logic                   respawn,
    output logic [NUM_ENEMIES-1:0] enemy_alive,
    output logic [31:0]            seconds,
    output logic [3:0]             lives,
    output logic [15:0]            score,
    output logic [9:0]             leds
);

    localparam logic [15:0] FRAME_LAST   = 16'(FRAMES_PER_SECOND - 1);
    localparam logic [15:0] DEATH_LAST   = 16'(DEATH_FRAMES - 1);
    localparam logic [31:0] SECONDS_INIT = 32'(TIME_LIMIT);
    localparam logic [3:0]  LIVES_INIT   = 4'(START_LIVES);
    localparam logic [31:0] STOMP_VALUE  = 32'(STOMP_POINTS);

    game_state_t            state_next;
    logic                   start_pulse;
    logic [NUM_ENEMIES-1:0] hit_eff;
    logic [NUM_ENEMIES-1:0] stomp_eff;
    logic                   death_event;
    logic [15:0]            frame_count;
    logic [15:0]            frame_count_next;
    logic [15:0]            death_count;
    logic [15:0]            death_count_next;
    logic [31:0]            seconds_next;
    logic [3:0]             lives_next;
    logic [15:0]            score_next;
    logic [NUM_ENEMIES-1:0] alive_next;

    edge_pulse #(
        .SYNC_STAGES (0),
        .ACTIVE_LOW  (VSYNC_ACTIVE_LOW)
    ) u_vsync_edge (
        .clk   (vga_clock),
        .reset (reset),
        .level (vsync),
        .pulse (frame_tick)
    );

    edge_pulse #(
        .SYNC_STAGES (2),
        .ACTIVE_LOW  (BUTTON_ACTIVE_LOW)
    ) u_start_edge (
        .clk   (vga_clock),
        .reset (reset),
        .level (start_button),
        .pulse (start_pulse)
    );

    // A stomp on an enemy overrides a hit on that same enemy; dead enemies never interact.
    assign hit_eff     = enemy_hit & ~enemy_stomp & enemy_alive;
    assign stomp_eff   = enemy_stomp & enemy_alive;
    assign death_event = (|hit_eff) || mario_fell || (seconds == 32'd0);

    // State register.
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; play events are only evaluated on frame ticks.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_pulse) state_next = PLAYING;
            end
            PLAYING: begin
                if (frame_tick) begin
                    if (goal_reached)     state_next = WON;
                    else if (death_event) state_next = DYING;
                end
            end
            DYING: begin
                if (frame_tick && death_count == DEATH_LAST) begin
                    state_next = (lives == 4'd0) ? GAME_OVER : RESPAWN;
                end
            end
            RESPAWN: begin
                state_next = PLAYING;
            end
            GAME_OVER, WON: begin
                if (start_pulse) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        freeze  = (state != PLAYING);
        respawn = (state == RESPAWN);
    end

    // Session counters: timer, lives, score and alive mask updates per state.
    always_comb begin
        seconds_next     = seconds;
        lives_next       = lives;
        score_next       = score;
        alive_next       = enemy_alive;
        frame_count_next = frame_count;
        death_count_next = death_count;
        case (state)
            IDLE: begin
                if (start_pulse) begin
                    seconds_next     = SECONDS_INIT;
                    lives_next       = LIVES_INIT;
                    score_next       = 16'd0;
                    alive_next       = '1;
                    frame_count_next = 16'd0;
                end
            end
            PLAYING: begin
                if (frame_tick) begin
                    if (goal_reached) begin
                        score_next = score_add(score, seconds);
                    end else if (death_event) begin
                        lives_next       = (lives == 4'd0) ? 4'd0 : lives - 4'd1;
                        death_count_next = 16'd0;
                    end else begin
                        alive_next = enemy_alive & ~stomp_eff;
                        score_next = score_add(score, STOMP_VALUE * popcount8(8'(stomp_eff)));
                        if (frame_count == FRAME_LAST) begin
                            frame_count_next = 16'd0;
                            if (seconds != 32'd0) seconds_next = seconds - 32'd1;
                        end else begin
                            frame_count_next = frame_count + 16'd1;
                        end
                    end
                end
            end
            DYING: begin
                if (frame_tick) begin
                    death_count_next = death_count + 16'd1;
                    if (death_count == DEATH_LAST && lives != 4'd0) begin
                        seconds_next     = SECONDS_INIT;
                        alive_next       = '1;
                        frame_count_next = 16'd0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Session counter registers.
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            seconds     <= SECONDS_INIT;
            lives       <= LIVES_INIT;
            score       <= 16'd0;
            enemy_alive <= '1;
            frame_count <= 16'd0;
            death_count <= 16'd0;
        end else begin
            seconds     <= seconds_next;
            lives       <= lives_next;
            score       <= score_next;
            enemy_alive <= alive_next;
            frame_count <= frame_count_next;
            death_count <= death_count_next;
        end
    end

    // LED status register built from next values so it always agrees with state and lives.
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            leds <= {IDLE, lives_bar(LIVES_INIT)};
        end else begin
            leds <= {state_next, lives_bar(lives_next)};
        end
    end

endmodule

// File: tb/tb_game_session_controller.sv
// Scoreboard bench for game_session_controller: stimulus drives frames, start
// presses and resets while a frame-level reference model queues the expected
// session snapshot; a monitor pops and compares whenever the DUT presents one.
module tb_game_session_controller;
    import game_session_pkg::*;

    localparam int NE  = 2;
    localparam int FPS = 2;
    localparam int TL  = 3;
    localparam int SL  = 2;
    localparam int DF  = 2;
    localparam int SP  = 100;

    logic          vga_clock = 1'b0;
    logic          reset;
    logic          vsync;
    logic          start_button;
    logic [NE-1:0] enemy_hit;
    logic [NE-1:0] enemy_stomp;
    logic          mario_fell;
    logic          goal_reached;
    game_state_t   state;
    logic          frame_tick;
    logic          freeze;
    logic          respawn;
    logic [NE-1:0] enemy_alive;
    logic [31:0]   seconds;
    logic [3:0]    lives;
    logic [15:0]   score;
    logic [9:0]    leds;

    typedef struct {
        game_state_t   st;
        int            lives;
        int            seconds;
        int            score;
        logic [NE-1:0] alive;
    } snap_t;

    snap_t         exp_q[$];
    bit            req_pending = 1'b0;
    int            check_count = 0;
    int            pass_count  = 0;

    game_state_t   m_state;
    int            m_lives;
    int            m_seconds;
    int            m_score;
    int            m_frame;
    int            m_death;
    logic [NE-1:0] m_alive;

    game_session_controller #(
        .NUM_ENEMIES       (NE),
        .FRAMES_PER_SECOND (FPS),
        .TIME_LIMIT        (TL),
        .START_LIVES       (SL),
        .DEATH_FRAMES      (DF),
        .STOMP_POINTS      (SP),
        .VSYNC_ACTIVE_LOW  (1'b1),
        .BUTTON_ACTIVE_LOW (1'b1)
    ) dut (
        .vga_clock    (vga_clock),
        .reset        (reset),
        .vsync        (vsync),
        .start_button (start_button),
        .enemy_hit    (enemy_hit),
        .enemy_stomp  (enemy_stomp),
        .mario_fell   (mario_fell),
        .goal_reached (goal_reached),
        .state        (state),
        .frame_tick   (frame_tick),
        .freeze       (freeze),
        .respawn      (respawn),
        .enemy_alive  (enemy_alive),
        .seconds      (seconds),
        .lives        (lives),
        .score        (score),
        .leds         (leds)
    );

    always #5 vga_clock = ~vga_clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    // ---------------- reference model (frame-level session rules) ----------------
    function automatic void pushExpect();
        snap_t s;
        s.st      = m_state;
        s.lives   = m_lives;
        s.seconds = m_seconds;
        s.score   = m_score;
        s.alive   = m_alive;
        exp_q.push_back(s);
    endfunction

    function automatic void newRound();
        m_seconds = TL;
        m_frame   = 0;
        m_alive   = '1;
    endfunction

    function automatic void modelReset();
        m_state = IDLE;
        m_lives = SL;
        m_score = 0;
        m_death = 0;
        newRound();
    endfunction

    function automatic int capScore(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic void modelStart();
        if (m_state == IDLE) begin
            m_state = PLAYING;
            m_lives = SL;
            m_score = 0;
            newRound();
        end else if (m_state == GAME_OVER || m_state == WON) begin
            m_state = IDLE;
        end
    endfunction

    function automatic void modelFrame(input logic [NE-1:0] hit, input logic [NE-1:0] stomp,
                                       input logic fell, input logic goal);
        logic [NE-1:0] hit_eff;
        logic [NE-1:0] stomp_eff;
        hit_eff   = hit & ~stomp & m_alive;
        stomp_eff = stomp & m_alive;
        if (m_state == PLAYING) begin
            if (goal) begin
                m_score = capScore(m_score + m_seconds);
                m_state = WON;
            end else if (hit_eff != 0 || fell || m_seconds == 0) begin
                if (m_lives > 0) m_lives--;
                m_death = 0;
                m_state = DYING;
            end else begin
                m_alive = m_alive & ~stomp_eff;
                m_score = capScore(m_score + SP * $countones(stomp_eff));
                m_frame++;
                if (m_frame == FPS) begin
                    m_frame = 0;
                    if (m_seconds > 0) m_seconds--;
                end
            end
            pushExpect();
        end else if (m_state == DYING) begin
            m_death++;
            if (m_death == DF) begin
                if (m_lives == 0) begin
                    m_state = GAME_OVER;
                    pushExpect();
                end else begin
                    m_state = RESPAWN;
                    newRound();
                    pushExpect();
                    m_state = PLAYING;
                end
            end else begin
                pushExpect();
            end
        end else begin
            pushExpect();
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic [NE-1:0] hit, input logic [NE-1:0] stomp,
                                 input logic fell, input logic goal);
        @(negedge vga_clock);
        enemy_hit    = hit;
        enemy_stomp  = stomp;
        mario_fell   = fell;
        goal_reached = goal;
        vsync        = 1'b0;
        modelFrame(hit, stomp, fell, goal);
        @(negedge vga_clock);
        @(negedge vga_clock);
        vsync        = 1'b1;
        enemy_hit    = '0;
        enemy_stomp  = '0;
        mario_fell   = 1'b0;
        goal_reached = 1'b0;
        repeat (2) @(negedge vga_clock);
    endtask

    task automatic pressStart(input int hold_cycles);
        @(negedge vga_clock);
        start_button = 1'b0;
        repeat (3) @(posedge vga_clock);
        #1;
        pushExpect();
        req_pending = 1'b1;
        @(posedge vga_clock);
        #1;
        modelStart();
        pushExpect();
        req_pending = 1'b1;
        repeat (hold_cycles + 1) @(posedge vga_clock);
        #1;
        pushExpect();
        req_pending = 1'b1;
        @(negedge vga_clock);
        start_button = 1'b1;
        repeat (4) @(negedge vga_clock);
    endtask

    task automatic applyReset();
        @(negedge vga_clock);
        reset        = 1'b0;
        vsync        = 1'b1;
        start_button = 1'b1;
        enemy_hit    = '0;
        enemy_stomp  = '0;
        mario_fell   = 1'b0;
        goal_reached = 1'b0;
        @(posedge vga_clock);
        #1;
        modelReset();
        pushExpect();
        req_pending = 1'b1;
        @(negedge vga_clock);
        reset = 1'b1;
        repeat (3) @(negedge vga_clock);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        snap_t e;
        bit    tick_prev;
        int    bar_n;
        tick_prev = 1'b0;
        forever begin
            @(negedge vga_clock);
            if (tick_prev || respawn === 1'b1 || req_pending) begin
                checkOutput("expect_available", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    bar_n = (e.lives > 7) ? 7 : e.lives;
                    checkOutput("state",       32'(state),       32'(e.st));
                    checkOutput("lives",       32'(lives),       32'(e.lives));
                    checkOutput("seconds",     seconds,          32'(e.seconds));
                    checkOutput("score",       32'(score),       32'(e.score));
                    checkOutput("enemy_alive", 32'(enemy_alive), 32'(e.alive));
                    checkOutput("freeze",      32'(freeze),      32'(e.st != PLAYING));
                    checkOutput("respawn",     32'(respawn),     32'(e.st == RESPAWN));
                    checkOutput("frame_tick",  32'(frame_tick),  32'd0);
                    checkOutput("leds",        32'(leds),        {19'd0, 3'(e.st), 7'((1 << bar_n) - 1)});
                end
                req_pending = 1'b0;
            end
            tick_prev = (frame_tick === 1'b1);
        end
    end

    // ---------------- test sequence ----------------
    initial begin : stimulus
        logic [NE-1:0] h;
        logic [NE-1:0] s;
        reset        = 1'b0;
        vsync        = 1'b1;
        start_button = 1'b1;
        enemy_hit    = '0;
        enemy_stomp  = '0;
        mario_fell   = 1'b0;
        goal_reached = 1'b0;
        modelReset();
        repeat (2) @(negedge vga_clock);
        applyReset();

        // Start, stomps, stomp-over-hit, then time out into a respawn.
        pressStart(3);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
        repeat (5) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);

        // Hit on a live enemy beside a stomp: death, stomp discarded, then game over.
        applyStimulus(2'b10, 2'b01, 1'b0, 1'b0);
        repeat (2) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        pressStart(2);

        // Fresh session: win with goal and fall together.
        pressStart(1);
        repeat (2) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        pressStart(6);

        // Falls until the last life, then reset in the middle of dying.
        pressStart(1);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0);
        repeat (2) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        applyReset();

        // Randomized sessions.
        for (int i = 0; i < 90; i++) begin
            if (m_state == PLAYING || m_state == DYING) begin
                h = ($urandom_range(0, 5) == 0) ? NE'($urandom) : '0;
                s = ($urandom_range(0, 2) == 0) ? NE'($urandom) : '0;
                applyStimulus(h, s, $urandom_range(0, 24) == 0, $urandom_range(0, 30) == 0);
            end else begin
                pressStart(1);
            end
        end

        repeat (4) @(negedge vga_clock);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
